// File: rtl/write_back_stage.sv
// rtl/write_back_stage.sv - final pipeline stage: load extension, register write-back, retire tracking
module write_back_stage #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memory_i_valid,
  output logic             write_back_o_ready,
  input  logic [4:0]       memory_i_rd,
  input  logic             memory_i_reg_wen,
  input  logic [1:0]       memory_i_wb_sel,
  input  logic [XLEN-1:0]  memory_i_alu_result,
  input  logic [XLEN-1:0]  memory_i_pc,
  input  logic [2:0]       memory_i_funct3,
  input  logic             lsu_i_rdata_valid,
  input  logic [XLEN-1:0]  lsu_i_rdata,
  output logic [4:0]       write_back_o_rd,
  output logic [XLEN-1:0]  write_back_o_data,
  output logic             write_back_o_reg_wen,
  output logic             write_back_o_commit,
  output logic [XLEN-1:0]  write_back_o_commit_pc,
  output logic             write_back_o_busy,
  output logic [4:0]       write_back_o_busy_rd,
  output logic [CNT_W-1:0] write_back_o_instret,
  output logic             write_back_o_err
);

  typedef enum logic [1:0] {IDLE, WAIT_LOAD, COMMIT} state_t;

  localparam logic [1:0] WB_LOAD = 2'b01;
  localparam logic [1:0] WB_PC4  = 2'b10;

  state_t           state_q, state_d;
  logic [4:0]       rd_q;
  logic             reg_wen_q;
  logic [2:0]       off_q;
  logic [XLEN-1:0]  pc_q;
  logic [2:0]       funct3_q;
  logic [XLEN-1:0]  data_q;
  logic [CNT_W-1:0] instret_q;
  logic             err_q;

  logic             accept;
  logic             load_resp;
  logic             enter_commit;
  logic [XLEN-1:0]  load_shifted;
  logic [XLEN-1:0]  load_ext;

  assign write_back_o_ready = (state_q == IDLE) || (state_q == COMMIT);
  assign accept       = memory_i_valid && write_back_o_ready;
  assign load_resp    = (state_q == WAIT_LOAD) && lsu_i_rdata_valid;
  assign enter_commit = (accept && (memory_i_wb_sel != WB_LOAD)) || load_resp;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state selection
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, COMMIT: begin
        if (accept) begin
          state_d = (memory_i_wb_sel == WB_LOAD) ? WAIT_LOAD : COMMIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT_LOAD: begin
        if (lsu_i_rdata_valid) begin
          state_d = COMMIT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Align the raw doubleword to the addressed byte, then size/sign-extend it
  always_comb begin
    load_shifted = lsu_i_rdata >> {off_q, 3'b000};
    load_ext     = load_shifted;
    case (funct3_q)
      3'd0: load_ext = {{(XLEN-8){load_shifted[7]}}, load_shifted[7:0]};
      3'd1: load_ext = {{(XLEN-16){load_shifted[15]}}, load_shifted[15:0]};
      3'd2: load_ext = {{(XLEN-32){load_shifted[31]}}, load_shifted[31:0]};
      3'd4: load_ext = {{(XLEN-8){1'b0}}, load_shifted[7:0]};
      3'd5: load_ext = {{(XLEN-16){1'b0}}, load_shifted[15:0]};
      3'd6: load_ext = {{(XLEN-32){1'b0}}, load_shifted[31:0]};
      default: load_ext = load_shifted;
    endcase
  end

  // Instruction latch, result data, retire counter and sticky error
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q      <= '0;
      reg_wen_q <= 1'b0;
      off_q     <= '0;
      pc_q      <= '0;
      funct3_q  <= '0;
      data_q    <= '0;
      instret_q <= '0;
      err_q     <= 1'b0;
    end else begin
      if (accept) begin
        rd_q      <= memory_i_rd;
        reg_wen_q <= memory_i_reg_wen;
        off_q     <= memory_i_alu_result[2:0];
        pc_q      <= memory_i_pc;
        funct3_q  <= memory_i_funct3;
        // Loads overwrite this when their response arrives
        data_q    <= (memory_i_wb_sel == WB_PC4) ? memory_i_pc + XLEN'(4)
                                                 : memory_i_alu_result;
      end
      if (load_resp) begin
        data_q <= load_ext;
      end
      if (enter_commit) begin
        instret_q <= instret_q + CNT_W'(1);
      end
      if ((lsu_i_rdata_valid && (state_q != WAIT_LOAD)) ||
          (load_resp && (funct3_q == 3'd7))) begin
        err_q <= 1'b1;
      end
    end
  end

  // Register-file, commit and hazard outputs decoded from registered state
  always_comb begin
    write_back_o_rd        = '0;
    write_back_o_data      = '0;
    write_back_o_reg_wen   = 1'b0;
    write_back_o_commit    = 1'b0;
    write_back_o_commit_pc = '0;
    if (state_q == COMMIT) begin
      write_back_o_rd        = rd_q;
      write_back_o_data      = data_q;
      write_back_o_reg_wen   = reg_wen_q && (rd_q != 5'd0);
      write_back_o_commit    = 1'b1;
      write_back_o_commit_pc = pc_q;
    end
    write_back_o_busy    = (state_q != IDLE) && reg_wen_q && (rd_q != 5'd0);
    write_back_o_busy_rd = rd_q;
    write_back_o_instret = instret_q;
    write_back_o_err     = err_q;
  end

endmodule

// File: tb/tb_write_back_stage.sv
// tb/tb_write_back_stage.sv - self-checking bench for write_back_stage
module tb_write_back_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memory_i_valid = 1'b0;
  logic        write_back_o_ready;
  logic [4:0]  memory_i_rd = '0;
  logic        memory_i_reg_wen = 1'b0;
  logic [1:0]  memory_i_wb_sel = '0;
  logic [63:0] memory_i_alu_result = '0;
  logic [63:0] memory_i_pc = '0;
  logic [2:0]  memory_i_funct3 = '0;
  logic        lsu_i_rdata_valid = 1'b0;
  logic [63:0] lsu_i_rdata = '0;
  logic [4:0]  write_back_o_rd;
  logic [63:0] write_back_o_data;
  logic        write_back_o_reg_wen;
  logic        write_back_o_commit;
  logic [63:0] write_back_o_commit_pc;
  logic        write_back_o_busy;
  logic [4:0]  write_back_o_busy_rd;
  logic [63:0] write_back_o_instret;
  logic        write_back_o_err;

  int          checks = 0;
  int          errors = 0;
  logic [63:0] model_instret = '0;
  logic        model_err = 1'b0;

  write_back_stage #(.XLEN(64), .CNT_W(64)) dut (
    .clk(clk), .rst(rst),
    .memory_i_valid(memory_i_valid), .write_back_o_ready(write_back_o_ready),
    .memory_i_rd(memory_i_rd), .memory_i_reg_wen(memory_i_reg_wen),
    .memory_i_wb_sel(memory_i_wb_sel), .memory_i_alu_result(memory_i_alu_result),
    .memory_i_pc(memory_i_pc), .memory_i_funct3(memory_i_funct3),
    .lsu_i_rdata_valid(lsu_i_rdata_valid), .lsu_i_rdata(lsu_i_rdata),
    .write_back_o_rd(write_back_o_rd), .write_back_o_data(write_back_o_data),
    .write_back_o_reg_wen(write_back_o_reg_wen), .write_back_o_commit(write_back_o_commit),
    .write_back_o_commit_pc(write_back_o_commit_pc), .write_back_o_busy(write_back_o_busy),
    .write_back_o_busy_rd(write_back_o_busy_rd), .write_back_o_instret(write_back_o_instret),
    .write_back_o_err(write_back_o_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference result: byte-wise selection from the addressed offset, then size/sign
  function automatic logic [63:0] model_data(input logic [1:0] sel, input logic [63:0] alu,
                                             input logic [63:0] pc, input logic [2:0] f3,
                                             input logic [63:0] rdata);
    logic [63:0] v;
    int off, nbytes;
    bit sgn;
    if (sel == 2'b10) return pc + 64'd4;
    if (sel != 2'b01) return alu;
    off = int'(alu[2:0]);
    case (f3[1:0])
      2'd0: nbytes = 1;
      2'd1: nbytes = 2;
      2'd2: nbytes = 4;
      default: nbytes = 8;
    endcase
    if (f3 == 3'd7) nbytes = 8;
    sgn = (f3[2] == 1'b0);
    v = '0;
    for (int i = 0; i < nbytes; i++) begin
      if (i + off < 8) v = v | (64'((rdata >> (8 * (i + off))) & 64'hFF) << (8 * i));
    end
    if (sgn && nbytes < 8 && v[8*nbytes-1]) v = v | (~64'd0 << (8 * nbytes));
    return v;
  endfunction

  task automatic do_insn(input logic [4:0] rd, input logic wen, input logic [1:0] sel,
                         input logic [63:0] alu, input logic [63:0] pc, input logic [2:0] f3,
                         input int delay, input logic [63:0] rdata);
    logic [63:0] exp_data;
    logic exp_wen;
    exp_data = model_data(sel, alu, pc, f3, rdata);
    exp_wen  = wen && (rd != 5'd0);
    memory_i_valid = 1'b1; memory_i_rd = rd; memory_i_reg_wen = wen; memory_i_wb_sel = sel;
    memory_i_alu_result = alu; memory_i_pc = pc; memory_i_funct3 = f3;
    checks++;
    if (write_back_o_ready !== 1'b1) begin errors++; $display("FAIL accept_ready got %b exp 1", write_back_o_ready); end
    tick;
    memory_i_valid = 1'b0;
    if (sel == 2'b01) begin
      for (int d = 0; d < delay; d++) begin
        checks++;
        if (write_back_o_ready !== 1'b0 || write_back_o_reg_wen !== 1'b0) begin
          errors++; $display("FAIL wait_ready got ready=%b wen=%b exp 0 0", write_back_o_ready, write_back_o_reg_wen);
        end
        tick;
      end
      checks++;
      if (write_back_o_busy !== exp_wen || (exp_wen && write_back_o_busy_rd !== rd)) begin
        errors++; $display("FAIL wait_busy got %b rd=%0d exp %b rd=%0d", write_back_o_busy, write_back_o_busy_rd, exp_wen, rd);
      end
      lsu_i_rdata_valid = 1'b1; lsu_i_rdata = rdata;
      tick;
      lsu_i_rdata_valid = 1'b0;
      if (f3 == 3'd7) model_err = 1'b1;
    end
    model_instret = model_instret + 64'd1;
    checks++;
    if (write_back_o_commit !== 1'b1 || write_back_o_reg_wen !== exp_wen || write_back_o_rd !== rd) begin
      errors++; $display("FAIL commit_ctl got c=%b wen=%b rd=%0d exp c=1 wen=%b rd=%0d",
                         write_back_o_commit, write_back_o_reg_wen, write_back_o_rd, exp_wen, rd);
    end
    checks++;
    if (write_back_o_data !== exp_data) begin
      errors++; $display("FAIL commit_data sel=%0d f3=%0d got %h exp %h", sel, f3, write_back_o_data, exp_data);
    end
    checks++;
    if (write_back_o_commit_pc !== pc || write_back_o_instret !== model_instret || write_back_o_err !== model_err) begin
      errors++; $display("FAIL commit_info got pc=%h n=%0d err=%b exp pc=%h n=%0d err=%b",
                         write_back_o_commit_pc, write_back_o_instret, write_back_o_err, pc, model_instret, model_err);
    end
    checks++;
    if (write_back_o_busy !== exp_wen) begin errors++; $display("FAIL commit_busy got %b exp %b", write_back_o_busy, exp_wen); end
    tick;
    checks++;
    if (write_back_o_commit !== 1'b0 || write_back_o_reg_wen !== 1'b0 || write_back_o_rd !== 5'd0 ||
        write_back_o_data !== 64'd0 || write_back_o_ready !== 1'b1 || write_back_o_busy !== 1'b0) begin
      errors++; $display("FAIL post_commit got c=%b wen=%b rd=%0d data=%h rdy=%b busy=%b exp 0 0 0 0 1 0",
                         write_back_o_commit, write_back_o_reg_wen, write_back_o_rd, write_back_o_data,
                         write_back_o_ready, write_back_o_busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick; tick;
    rst = 1'b0;
    model_instret = '0; model_err = 1'b0;
    checks++;
    if (write_back_o_ready !== 1'b1 || write_back_o_commit !== 1'b0 || write_back_o_reg_wen !== 1'b0 ||
        write_back_o_rd !== 5'd0 || write_back_o_data !== 64'd0 || write_back_o_commit_pc !== 64'd0 ||
        write_back_o_busy !== 1'b0 || write_back_o_busy_rd !== 5'd0 || write_back_o_instret !== 64'd0 ||
        write_back_o_err !== 1'b0) begin
      errors++; $display("FAIL reset got rdy=%b c=%b wen=%b rd=%0d data=%h n=%0d err=%b exp 1 0 0 0 0 0 0",
                         write_back_o_ready, write_back_o_commit, write_back_o_reg_wen, write_back_o_rd,
                         write_back_o_data, write_back_o_instret, write_back_o_err);
    end
  endtask

  task automatic test_alu;
    do_insn(5'd5, 1'b1, 2'b00, 64'h1234, 64'h1000, 3'd0, 0, 64'd0);
    do_insn(5'd9, 1'b1, 2'b11, 64'hCAFE_F00D_1234_5678, 64'h1004, 3'd3, 0, 64'd0);
  endtask

  task automatic test_loads;
    do_insn(5'd7, 1'b1, 2'b01, 64'h1003, 64'h2000, 3'd0, 2, 64'h0000_0000_8000_0000);
    do_insn(5'd7, 1'b1, 2'b01, 64'h1003, 64'h2004, 3'd4, 2, 64'h0000_0000_8000_0000);
    do_insn(5'd8, 1'b1, 2'b01, 64'h1004, 64'h2008, 3'd6, 2, 64'hDEAD_BEEF_0000_0000);
    do_insn(5'd8, 1'b1, 2'b01, 64'h1004, 64'h200C, 3'd2, 0, 64'hDEAD_BEEF_0000_0000);
    do_insn(5'd3, 1'b1, 2'b01, 64'h1006, 64'h2010, 3'd1, 1, 64'h8123_4567_89AB_CDEF);
  endtask

  task automatic test_pc4;
    do_insn(5'd1, 1'b1, 2'b10, 64'h0, 64'h8000_0020, 3'd0, 0, 64'd0);
    do_insn(5'd0, 1'b1, 2'b10, 64'h0, 64'h8000_0020, 3'd0, 0, 64'd0);
    do_insn(5'd2, 1'b1, 2'b10, 64'h0, 64'hFFFF_FFFF_FFFF_FFFE, 3'd0, 0, 64'd0);
  endtask

  task automatic test_back_to_back;
    logic [4:0]  rds [4];
    logic [63:0] alus [4];
    for (int i = 0; i < 4; i++) begin
      rds[i]  = 5'(i + 10);
      alus[i] = {$urandom, $urandom};
    end
    memory_i_valid = 1'b1; memory_i_reg_wen = 1'b1; memory_i_wb_sel = 2'b00; memory_i_pc = 64'h3000;
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        memory_i_rd = rds[i]; memory_i_alu_result = alus[i];
      end else begin
        memory_i_valid = 1'b0;
      end
      if (i > 0) begin
        model_instret = model_instret + 64'd1;
        checks++;
        if (write_back_o_reg_wen !== 1'b1 || write_back_o_rd !== rds[i-1] || write_back_o_data !== alus[i-1] ||
            write_back_o_ready !== 1'b1 || write_back_o_instret !== model_instret) begin
          errors++; $display("FAIL b2b_%0d got wen=%b rd=%0d data=%h rdy=%b n=%0d exp 1 %0d %h 1 %0d", i - 1,
                             write_back_o_reg_wen, write_back_o_rd, write_back_o_data, write_back_o_ready,
                             write_back_o_instret, rds[i-1], alus[i-1], model_instret);
        end
      end
      tick;
    end
    checks++;
    if (write_back_o_reg_wen !== 1'b0 || write_back_o_commit !== 1'b0) begin
      errors++; $display("FAIL b2b_end got wen=%b c=%b exp 0 0", write_back_o_reg_wen, write_back_o_commit);
    end
  endtask

  task automatic test_err;
    lsu_i_rdata_valid = 1'b1; lsu_i_rdata = 64'hFFFF;
    tick;
    lsu_i_rdata_valid = 1'b0;
    model_err = 1'b1;
    checks++;
    if (write_back_o_err !== 1'b1 || write_back_o_reg_wen !== 1'b0 || write_back_o_commit !== 1'b0 ||
        write_back_o_instret !== model_instret) begin
      errors++; $display("FAIL stray_resp got err=%b wen=%b c=%b n=%0d exp 1 0 0 %0d", write_back_o_err,
                         write_back_o_reg_wen, write_back_o_commit, write_back_o_instret, model_instret);
    end
    do_insn(5'd4, 1'b1, 2'b00, 64'h55, 64'h4000, 3'd0, 0, 64'd0);
    test_reset;
    do_insn(5'd6, 1'b1, 2'b01, 64'h1002, 64'h4004, 3'd7, 1, 64'h1122_3344_5566_7788);
    tick;
    checks++;
    if (write_back_o_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", write_back_o_err); end
  endtask

  task automatic test_reset_wait_load;
    memory_i_valid = 1'b1; memory_i_rd = 5'd12; memory_i_reg_wen = 1'b1; memory_i_wb_sel = 2'b01;
    memory_i_alu_result = 64'h0; memory_i_funct3 = 3'd3;
    tick;
    memory_i_valid = 1'b0;
    rst = 1'b1; lsu_i_rdata_valid = 1'b1; lsu_i_rdata = 64'h1234;
    tick;
    rst = 1'b0; lsu_i_rdata_valid = 1'b0;
    model_instret = '0; model_err = 1'b0;
    checks++;
    if (write_back_o_ready !== 1'b1 || write_back_o_reg_wen !== 1'b0 || write_back_o_commit !== 1'b0 ||
        write_back_o_instret !== 64'd0 || write_back_o_err !== 1'b0 || write_back_o_busy !== 1'b0) begin
      errors++; $display("FAIL rst_wait_load got rdy=%b wen=%b c=%b n=%0d err=%b busy=%b exp 1 0 0 0 0 0",
                         write_back_o_ready, write_back_o_reg_wen, write_back_o_commit,
                         write_back_o_instret, write_back_o_err, write_back_o_busy);
    end
    tick;
    checks++;
    if (write_back_o_commit !== 1'b0 || write_back_o_reg_wen !== 1'b0) begin
      errors++; $display("FAIL rst_no_late_write got c=%b wen=%b exp 0 0", write_back_o_commit, write_back_o_reg_wen);
    end
  endtask

  task automatic test_random;
    for (int n = 0; n < 60; n++) begin
      do_insn(5'($urandom), 1'($urandom), 2'($urandom_range(0, 3)), {$urandom, $urandom},
              {$urandom, $urandom}, 3'($urandom_range(0, 6)), int'($urandom_range(0, 3)),
              {$urandom, $urandom});
    end
  endtask

  initial begin
    test_reset;
    test_alu;
    test_loads;
    test_pc4;
    test_back_to_back;
    test_random;
    test_err;
    test_reset_wait_load;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
